// File: rtl/tb_scoreboard.sv
// tb_scoreboard: in-order expected/actual comparator with an expected-word FIFO and drain handshake.
// Defining TB_SCOREBOARD_MASK_EN adds a per-entry exp_mask port that limits which bits are compared.
module tb_scoreboard #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned CNTW    = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   exp_valid,
   output logic                   exp_ready,
   input  logic [WIDTH-1:0]       exp_data,
`ifdef TB_SCOREBOARD_MASK_EN
   input  logic [WIDTH-1:0]       exp_mask,
`endif
   input  logic                   act_valid,
   input  logic [WIDTH-1:0]       act_data,
   input  logic                   drain,
   output logic                   cmp_valid,
   output logic                   cmp_pass,
   output logic [WIDTH-1:0]       cmp_exp,
   output logic [WIDTH-1:0]       cmp_act,
   output logic [CNTW-1:0]        match_cnt,
   output logic [CNTW-1:0]        mismatch_cnt,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   err_unexpected,
   output logic                   err_timeout,
   output logic                   drain_done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
   localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_TOUT} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] mem_d [DEPTH];
`ifdef TB_SCOREBOARD_MASK_EN
   logic [WIDTH-1:0] mem_m [DEPTH];
`endif
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [PW-1:0]    count;
   logic [TW-1:0]    tcnt;
   logic             empty, full, terminal;
   logic             push, pop, bypass, unexp, wr_en, pass_nx;
   logic [WIDTH-1:0] sel_exp, sel_mask, diff;

   always_comb begin
      empty     = (count == '0);
      full      = (count == FULL_CNT);
      terminal  = (state == S_DONE) || (state == S_TOUT);
      exp_ready = (state == S_RUN) && !full;
      push      = exp_valid && exp_ready;
      // Terminal states no longer pop: any actual word there is unexpected.
      pop       = act_valid && !empty && !terminal;
      bypass    = act_valid && empty && push;
      unexp     = act_valid && !pop && !bypass;
      wr_en     = push && !bypass;

      sel_exp  = '0;
      sel_mask = '0;
      if (pop) begin
         sel_exp = mem_d[rd_ptr];
`ifdef TB_SCOREBOARD_MASK_EN
         sel_mask = mem_m[rd_ptr];
`else
         sel_mask = '1;
`endif
      end else if (bypass) begin
         sel_exp = exp_data;
`ifdef TB_SCOREBOARD_MASK_EN
         sel_mask = exp_mask;
`else
         sel_mask = '1;
`endif
      end

      // Unknown bits make the equality test non-true, so they fall to a fail.
      diff    = (sel_exp ^ act_data) & sel_mask;
      pass_nx = 1'b0;
      if (!unexp) begin
         if (diff == '0) pass_nx = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_RUN:   if (drain) state_nx = S_DRAIN;
         S_DRAIN: begin
            if (empty)              state_nx = S_DONE;
            else if (tcnt == TLAST) state_nx = S_TOUT;
         end
         default: state_nx = state;
      endcase
      drain_done  = (state == S_DONE);
      err_timeout = (state == S_TOUT);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_d[wr_ptr] <= exp_data;
`ifdef TB_SCOREBOARD_MASK_EN
         mem_m[wr_ptr] <= exp_mask;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_RUN;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         tcnt           <= '0;
         cmp_valid      <= 1'b0;
         cmp_pass       <= 1'b0;
         cmp_exp        <= '0;
         cmp_act        <= '0;
         match_cnt      <= '0;
         mismatch_cnt   <= '0;
         err_unexpected <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_DRAIN) tcnt <= tcnt + TW'(1);
         else                  tcnt <= '0;

         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + PW'(1);
            2'b01:   count <= count - PW'(1);
            default: count <= count;
         endcase

         cmp_valid <= act_valid;
         if (act_valid) begin
            cmp_pass <= pass_nx;
            cmp_exp  <= sel_exp;
            cmp_act  <= act_data;
            if (pass_nx) begin
               if (match_cnt != '1) match_cnt <= match_cnt + CNTW'(1);
            end else begin
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNTW'(1);
            end
         end
         if (unexp) err_unexpected <= 1'b1;
      end
   end

   assign pending = count;

endmodule

// File: tb/tb_tb_scoreboard.sv
// Directed self-checking bench for tb_scoreboard: a queue model predicts each compare result.
module tb_tb_scoreboard;

   localparam int unsigned W = 8;
   localparam int unsigned D = 4;
   localparam int unsigned C = 4;
   localparam int unsigned T = 8;
   localparam int unsigned CMAX = (1 << C) - 1;

   logic         clk = 1'b0;
   logic         rst, exp_valid, exp_ready, act_valid, drain;
   logic [W-1:0] exp_data, exp_mask, act_data, cmp_exp, cmp_act;
   logic         cmp_valid, cmp_pass, err_unexpected, err_timeout, drain_done;
   logic [C-1:0] match_cnt, mismatch_cnt;
   logic [2:0]   pending;

   tb_scoreboard #(.WIDTH(W), .DEPTH(D), .CNTW(C), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
`ifdef TB_SCOREBOARD_MASK_EN
      .exp_mask(exp_mask),
`endif
      .act_valid(act_valid), .act_data(act_data), .drain(drain),
      .cmp_valid(cmp_valid), .cmp_pass(cmp_pass), .cmp_exp(cmp_exp), .cmp_act(cmp_act),
      .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .pending(pending),
      .err_unexpected(err_unexpected), .err_timeout(err_timeout), .drain_done(drain_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] e;
      logic [W-1:0] a;
      logic         p;
   } res_t;

   res_t         res_q[$];
   logic [W-1:0] mq_d[$];
   logic [W-1:0] mq_m[$];
   int unsigned  m_match, m_mis, m_mode;   // m_mode: 0 run, 1 drain, 2 terminal
   int           tests = 0;
   int           fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      res_t r;
      @(posedge clk);
      #1;
      if (cmp_valid === 1'b1) begin
         if (res_q.size() == 0) chk("cmp_spurious", cmp_valid, 0);
         else begin
            r = res_q.pop_front();
            chk("cmp_pass", cmp_pass, r.p);
            chk("cmp_exp", cmp_exp, r.e);
            chk("cmp_act", cmp_act, r.a);
         end
      end else if (res_q.size() != 0) begin
         r = res_q.pop_front();
         chk("cmp_missing", cmp_valid, 1);
      end
   endtask

   task automatic model_clear();
      res_q.delete();
      mq_d.delete();
      mq_m.delete();
      m_match = 0;
      m_mis   = 0;
      m_mode  = 0;
   endtask

   task automatic do_reset();
      model_clear();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset();
      chk("rst_exp_ready", exp_ready, 1);
      chk("rst_pending", pending, 0);
      chk("rst_cmp_valid", cmp_valid, 0);
      chk("rst_cmp_pass", cmp_pass, 0);
      chk("rst_cmp_exp", cmp_exp, 0);
      chk("rst_cmp_act", cmp_act, 0);
      chk("rst_match", match_cnt, 0);
      chk("rst_mismatch", mismatch_cnt, 0);
      chk("rst_err_unexp", err_unexpected, 0);
      chk("rst_err_tout", err_timeout, 0);
      chk("rst_drain_done", drain_done, 0);
   endtask

   task automatic push(input logic [W-1:0] e, input logic [W-1:0] m);
      bit acc;
      acc = (m_mode == 0) && (mq_d.size() < D);
      chk("exp_ready", exp_ready, acc);
      exp_valid = 1'b1; exp_data = e; exp_mask = m;
      tick();
      exp_valid = 1'b0;
      if (acc) begin
         mq_d.push_back(e);
         mq_m.push_back(m);
      end
   endtask

   task automatic act(input logic [W-1:0] a, input bit wexp, input logic [W-1:0] e,
                      input logic [W-1:0] m, input bit wdrain);
      res_t         r;
      bit           acc;
      logic [W-1:0] mk;
      acc = wexp && (m_mode == 0) && (mq_d.size() < D);
      r.a = a;
      if (m_mode != 2 && mq_d.size() > 0) begin
         r.e = mq_d.pop_front();
         mk  = mq_m.pop_front();
         r.p = (((r.e ^ a) & mk) == '0);
      end else if (acc) begin
         r.e = e;
         r.p = (((e ^ a) & m) == '0);
         acc = 1'b0;
      end else begin
         r.e = '0;
         r.p = 1'b0;
      end
      if (acc) begin
         mq_d.push_back(e);
         mq_m.push_back(m);
      end
      if (r.p) begin
         if (m_match < CMAX) m_match++;
      end else begin
         if (m_mis < CMAX) m_mis++;
      end
      res_q.push_back(r);
      if (wdrain && m_mode == 0) m_mode = 1;
      act_valid = 1'b1; act_data = a;
      exp_valid = wexp; exp_data = e; exp_mask = m;
      drain     = wdrain;
      tick();
      act_valid = 1'b0; exp_valid = 1'b0; drain = 1'b0;
   endtask

   task automatic act1(input logic [W-1:0] a);
      act(a, 1'b0, '0, '1, 1'b0);
   endtask

   task automatic do_drain();
      if (m_mode == 0) m_mode = 1;
      drain = 1'b1;
      tick();
      drain = 1'b0;
   endtask

   task automatic check_counts();
      chk("match_cnt", match_cnt, m_match);
      chk("mismatch_cnt", mismatch_cnt, m_mis);
      chk("pending", pending, mq_d.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; exp_valid = 1'b0; exp_data = '0; exp_mask = '1;
      act_valid = 1'b0; act_data = '0; drain = 1'b0;

      do_reset();
      check_reset();

      // in-order passes
      push(8'hA5, '1); push(8'h3C, '1); push(8'hFF, '1);
      chk("pending_3", pending, 3);
      act1(8'hA5); act1(8'h3C); act1(8'hFF);
      check_counts();

      // data mismatch
      push(8'h10, '1);
      act1(8'h11);
      check_counts();

      // full FIFO refuses a push even while popping
      push(8'h01, '1); push(8'h02, '1); push(8'h03, '1); push(8'h04, '1);
      chk("pending_full", pending, D);
      chk("exp_ready_full", exp_ready, 0);
      act(8'h01, 1'b1, 8'h05, '1, 1'b0);
      chk("pending_after_pop", pending, 3);
      chk("exp_ready_after_pop", exp_ready, 1);
      act1(8'h02); act1(8'h03); act1(8'h04);
      check_counts();

      // bypass on empty FIFO, then unexpected
      act(8'h07, 1'b1, 8'h07, '1, 1'b0);
      chk("pending_bypass", pending, 0);
      chk("err_unexp_bypass", err_unexpected, 0);
      act1(8'h09);
      chk("err_unexp_set", err_unexpected, 1);
      check_counts();

      // mismatch counter saturation
      for (int i = 0; i < 14; i++) act1(8'h80 + 8'(i));
      check_counts();

      // drain to completion
      push(8'h20, '1); push(8'h21, '1);
      do_drain();
      chk("drain_exp_ready", exp_ready, 0);
      chk("drain_done_early", drain_done, 0);
      push(8'h99, '1);
      chk("pending_drain", pending, 2);
      act1(8'h20); act1(8'h21);
      chk("drain_done_wait", drain_done, 0);
      tick();
      m_mode = 2;
      chk("drain_done", drain_done, 1);
      chk("done_no_tout", err_timeout, 0);
      act1(8'h55);
      chk("done_still", drain_done, 1);
      check_counts();

      // drain timeout
      do_reset();
      check_reset();
      push(8'h30, '1); push(8'h31, '1);
      do_drain();
      act1(8'h30);
      repeat (6) tick();
      chk("tout_not_yet", err_timeout, 0);
      tick();
      m_mode = 2;
      chk("err_timeout", err_timeout, 1);
      chk("tout_no_done", drain_done, 0);
      chk("tout_exp_ready", exp_ready, 0);
      act1(8'h31);
      chk("tout_pending", pending, 1);
      chk("tout_err_unexp", err_unexpected, 1);
      check_counts();

      // drain in the same cycle as the final pop
      do_reset();
      push(8'h40, '1);
      act(8'h40, 1'b0, '0, '1, 1'b1);
      chk("lastpop_not_done", drain_done, 0);
      tick();
      m_mode = 2;
      chk("lastpop_done", drain_done, 1);
      check_counts();

`ifdef TB_SCOREBOARD_MASK_EN
      do_reset();
      push(8'hF0, 8'hF0);
      act1(8'hFF);
      act(8'h3A, 1'b1, 8'h30, 8'hF0, 1'b0);
      check_counts();
`endif

      // reset during drain with an actual word in flight
      do_reset();
      push(8'h66, '1);
      do_drain();
      model_clear();
      rst = 1'b1; act_valid = 1'b1; act_data = 8'h66;
      tick();
      rst = 1'b0; act_valid = 1'b0;
      check_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
